// File: rtl/regfile_sb_pkg.sv
// Shared types and constants for the regfile_sb register file with busy-bit scoreboard.
// The build option REGFILE_BYPASS_EN is consumed by regfile_sb and regfile_sb_scoreboard.
package regfile_sb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NREGS_DEF  = 8;

  // Address width derived from the register count; a single register still needs one bit.
  function automatic int addr_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int ADDR_W_DEF = addr_w(NREGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  localparam int RF_RESET_VAL = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between the control unit (master) and the regfile_sb register file (slave).
// The master drives addresses, strobes and write data; the slave returns data and scoreboard status.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF
);

  localparam int ADDR_W = addr_w(NREGS);

  logic [ADDR_W-1:0] rd_addr1;
  logic              rd_en1;
  logic [DATA_W-1:0] rd_data1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              rd_en2;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              hazard;
  logic [ADDR_W:0]   pending_cnt;
  logic              err_dbl_rsv;

  modport master (
    output rd_addr1, rd_en1, rd_addr2, rd_en2,
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data1, rd_data2, hazard, pending_cnt, err_dbl_rsv
  );

  modport slave (
    input  rd_addr1, rd_en1, rd_addr2, rd_en2,
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data1, rd_data2, hazard, pending_cnt, err_dbl_rsv
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: reservation/clear priority, busy popcount, sticky double-reserve flag, RAW hazard.
// With REGFILE_BYPASS_EN defined, a same-cycle write to the read address suppresses that port's hazard.
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREGS = NREGS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr_en,
  input  logic [addr_w(NREGS)-1:0]   i_wr_addr,
  input  logic                       i_rsv_en,
  input  logic [addr_w(NREGS)-1:0]   i_rsv_addr,
  input  logic                       i_rd_en1,
  input  logic [addr_w(NREGS)-1:0]   i_rd_addr1,
  input  logic                       i_rd_en2,
  input  logic [addr_w(NREGS)-1:0]   i_rd_addr2,
  output logic                       o_hazard,
  output logic [addr_w(NREGS):0]     o_pending_cnt,
  output logic                       o_err_dbl_rsv
);

  localparam int ADDR_W = addr_w(NREGS);

  logic [NREGS-1:0] r_busy;
  logic [ADDR_W:0]  r_pending_cnt;
  logic             r_err_dbl_rsv;

  logic [NREGS-1:0] w_busy_nxt;
  logic             w_dbl_rsv;
  logic             w_haz1;
  logic             w_haz2;
  logic             w_byp1;
  logic             w_byp2;

  // Write clears first, reservation applied after so a same-address reserve keeps the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wr_en) begin
      w_busy_nxt[i_wr_addr] = 1'b0;
    end
    if (i_rsv_en) begin
      w_busy_nxt[i_rsv_addr] = 1'b1;
    end
  end

  assign w_dbl_rsv = i_rsv_en && r_busy[i_rsv_addr] &&
                     !(i_wr_en && (i_wr_addr == i_rsv_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy        <= '0;
      r_pending_cnt <= '0;
      r_err_dbl_rsv <= 1'b0;
    end else begin
      r_busy        <= w_busy_nxt;
      r_pending_cnt <= (ADDR_W+1)'($countones(w_busy_nxt));
      if (w_dbl_rsv) begin
        r_err_dbl_rsv <= 1'b1;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign w_byp1 = i_wr_en && (i_rd_addr1 == i_wr_addr);
  assign w_byp2 = i_wr_en && (i_rd_addr2 == i_wr_addr);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign w_haz1 = i_rd_en1 && r_busy[i_rd_addr1] && !w_byp1;
  assign w_haz2 = i_rd_en2 && r_busy[i_rd_addr2] && !w_byp2;

  assign o_hazard      = w_haz1 || w_haz2;
  assign o_pending_cnt = r_pending_cnt;
  assign o_err_dbl_rsv = r_err_dbl_rsv;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file (2 combinational read ports, 1 write port) with busy-bit scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);

  localparam int ADDR_W = addr_w(NREGS);

  logic [DATA_W-1:0] r_regs [NREGS];

  logic [DATA_W-1:0] w_rd_data1;
  logic [DATA_W-1:0] w_rd_data2;
  logic              w_hazard;
  logic [ADDR_W:0]   w_pending_cnt;
  logic              w_err_dbl_rsv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= DATA_W'(RF_RESET_VAL);
      end
    end else if (bus.wr_en) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Without bypass a reader sees the stored value until the edge after the write.
  always_comb begin
    w_rd_data1 = r_regs[bus.rd_addr1];
    w_rd_data2 = r_regs[bus.rd_addr2];
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && (bus.rd_addr1 == bus.wr_addr)) begin
      w_rd_data1 = bus.wr_data;
    end
    if (bus.wr_en && (bus.rd_addr2 == bus.wr_addr)) begin
      w_rd_data2 = bus.wr_data;
    end
`endif
  end

  regfile_sb_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_en       (bus.wr_en),
    .i_wr_addr     (bus.wr_addr),
    .i_rsv_en      (bus.rsv_en),
    .i_rsv_addr    (bus.rsv_addr),
    .i_rd_en1      (bus.rd_en1),
    .i_rd_addr1    (bus.rd_addr1),
    .i_rd_en2      (bus.rd_en2),
    .i_rd_addr2    (bus.rd_addr2),
    .o_hazard      (w_hazard),
    .o_pending_cnt (w_pending_cnt),
    .o_err_dbl_rsv (w_err_dbl_rsv)
  );

  assign bus.rd_data1    = w_rd_data1;
  assign bus.rd_data2    = w_rd_data2;
  assign bus.hazard      = w_hazard;
  assign bus.pending_cnt = w_pending_cnt;
  assign bus.err_dbl_rsv = w_err_dbl_rsv;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-style bench for regfile_sb: an 8x8 instance for the main function and a 16x16 instance
// for the all-busy case. Expected outputs are queued by the stimulus and checked by a negedge monitor.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    int          dut;
    bit          cRd1;
    logic [15:0] rd1;
    bit          cRd2;
    logic [15:0] rd2;
    bit          cHaz;
    logic        hz;
    bit          cPend;
    logic [4:0]  pend;
    bit          cErr;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   nCompared;
  int   nMismatch;
  exp_t expQ [$];

  regfile_sb_if #(.DATA_W(8),  .NREGS(8))  if8 ();
  regfile_sb_if #(.DATA_W(16), .NREGS(16)) if16 ();

  regfile_sb #(.DATA_W(8), .NREGS(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  regfile_sb #(.DATA_W(16), .NREGS(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue the outputs the selected DUT must show during the current cycle.
  task automatic expectOut(input string name, input int dut,
                           input bit cRd1, input logic [15:0] rd1,
                           input bit cRd2, input logic [15:0] rd2,
                           input bit cHaz, input logic hz,
                           input bit cPend, input logic [4:0] pend,
                           input bit cErr, input logic err);
    exp_t e;
    e.name = name; e.dut = dut;
    e.cRd1 = cRd1; e.rd1 = rd1; e.cRd2 = cRd2; e.rd2 = rd2;
    e.cHaz = cHaz; e.hz = hz; e.cPend = cPend; e.pend = pend;
    e.cErr = cErr; e.err = err;
    expQ.push_back(e);
  endtask

  task automatic compareField(input string name, input string field,
                              input logic [15:0] act, input logic [15:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [15:0] aRd1, aRd2;
    logic [4:0]  aPend;
    logic        aHz, aErr;
    if (e.dut == 0) begin
      aRd1 = {8'h00, if8.rd_data1};
      aRd2 = {8'h00, if8.rd_data2};
      aHz  = if8.hazard;
      aPend = {1'b0, if8.pending_cnt};
      aErr = if8.err_dbl_rsv;
    end else begin
      aRd1 = if16.rd_data1;
      aRd2 = if16.rd_data2;
      aHz  = if16.hazard;
      aPend = if16.pending_cnt;
      aErr = if16.err_dbl_rsv;
    end
    if (e.cRd1)  compareField(e.name, "rd_data1", aRd1, e.rd1);
    if (e.cRd2)  compareField(e.name, "rd_data2", aRd2, e.rd2);
    if (e.cHaz)  compareField(e.name, "hazard", {15'd0, aHz}, {15'd0, e.hz});
    if (e.cPend) compareField(e.name, "pending_cnt", {11'd0, aPend}, {11'd0, e.pend});
    if (e.cErr)  compareField(e.name, "err_dbl_rsv", {15'd0, aErr}, {15'd0, e.err});
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  // Drive one cycle of stimulus on the 8x8 instance, just after the rising edge.
  task automatic applyStimulus(input logic wrEn, input logic [2:0] wrAddr, input reg_data_t wrData,
                               input logic rsvEn, input logic [2:0] rsvAddr,
                               input logic rdEn1, input logic [2:0] rdAddr1,
                               input logic rdEn2, input logic [2:0] rdAddr2);
    @(posedge clk);
    #1;
    if8.wr_en    = wrEn;
    if8.wr_addr  = wrAddr;
    if8.wr_data  = wrData;
    if8.rsv_en   = rsvEn;
    if8.rsv_addr = rsvAddr;
    if8.rd_en1   = rdEn1;
    if8.rd_addr1 = rdAddr1;
    if8.rd_en2   = rdEn2;
    if8.rd_addr2 = rdAddr2;
  endtask

  task automatic drive16(input logic wrEn, input logic [3:0] wrAddr, input logic [15:0] wrData,
                         input logic rsvEn, input logic [3:0] rsvAddr,
                         input logic rdEn1, input logic [3:0] rdAddr1,
                         input logic rdEn2, input logic [3:0] rdAddr2);
    @(posedge clk);
    #1;
    if16.wr_en    = wrEn;
    if16.wr_addr  = wrAddr;
    if16.wr_data  = wrData;
    if16.rsv_en   = rsvEn;
    if16.rsv_addr = rsvAddr;
    if16.rd_en1   = rdEn1;
    if16.rd_addr1 = rdAddr1;
    if16.rd_en2   = rdEn2;
    if16.rd_addr2 = rdAddr2;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nCompared = 0;
    nMismatch = 0;
    rst_n = 1'b0;
    if8.wr_en = 0;  if8.wr_addr = 0;  if8.wr_data = 0;  if8.rsv_en = 0;  if8.rsv_addr = 0;
    if8.rd_en1 = 0; if8.rd_addr1 = 0; if8.rd_en2 = 0;   if8.rd_addr2 = 0;
    if16.wr_en = 0; if16.wr_addr = 0; if16.wr_data = 0; if16.rsv_en = 0; if16.rsv_addr = 0;
    if16.rd_en1 = 0; if16.rd_addr1 = 0; if16.rd_en2 = 0; if16.rd_addr2 = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state and plain write/read
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 0, 1, 7);
    expectOut("reset_state", 0, 1, 16'h00, 1, 16'h00, 1, 0, 1, 5'd0, 1, 0);
    applyStimulus(1, 3, 8'hBB, 0, 0, 0, 3, 0, 0);
    expectOut("wr_same_cycle", 0, 1, BYP ? 16'hBB : 16'h00, 0, 0, 1, 0, 1, 5'd0, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 3, 0, 3);
    expectOut("write_read", 0, 1, 16'hBB, 1, 16'hBB, 1, 0, 1, 5'd0, 1, 0);

    // Reserve r5, observe hazard on each port and the rd_en mask, then resolve by write
    applyStimulus(0, 0, 8'h00, 1, 5, 1, 5, 0, 0);
    expectOut("rsv_issue", 0, 0, 0, 0, 0, 1, 0, 1, 5'd0, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 5, 0, 0);
    expectOut("raw_hazard_p1", 0, 0, 0, 0, 0, 1, 1, 1, 5'd1, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 5, 1, 5);
    expectOut("raw_hazard_p2", 0, 0, 0, 0, 0, 1, 1, 1, 5'd1, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 5, 0, 5);
    expectOut("hazard_masked", 0, 0, 0, 0, 0, 1, 0, 1, 5'd1, 0, 0);
    applyStimulus(1, 5, 8'hE4, 0, 0, 1, 5, 0, 0);
    expectOut("wr_resolve_same", 0, 1, BYP ? 16'hE4 : 16'h00, 0, 0, 1, !BYP, 1, 5'd1, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 5, 0, 0);
    expectOut("wr_resolve_next", 0, 1, 16'hE4, 0, 0, 1, 0, 1, 5'd0, 1, 0);

    // Same-cycle write+reserve on a busy register, then a true double reserve
    applyStimulus(0, 0, 8'h00, 1, 2, 0, 0, 0, 0);
    applyStimulus(1, 2, 8'h5A, 1, 2, 0, 0, 0, 0);
    expectOut("wr_rsv_issue", 0, 0, 0, 0, 0, 0, 0, 1, 5'd1, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 2, 0, 2);
    expectOut("wr_rsv_same", 0, 1, 16'h5A, 1, 16'h5A, 1, 1, 1, 5'd1, 1, 0);
    applyStimulus(0, 0, 8'h00, 1, 2, 0, 0, 0, 0);
    expectOut("dbl_rsv_issue", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    expectOut("dbl_rsv", 0, 0, 0, 0, 0, 0, 0, 1, 5'd1, 1, 1);
    applyStimulus(1, 2, 8'h11, 1, 4, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 2, 1, 4);
    expectOut("wr_rsv_diff", 0, 1, 16'h11, 0, 0, 1, 1, 1, 5'd1, 1, 1);
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 2, 0, 4);
    expectOut("r2_cleared", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);

    // Write to a busy register while it is being read
    applyStimulus(1, 6, 8'h33, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 6, 0, 0, 0, 0);
    applyStimulus(1, 6, 8'hAA, 0, 0, 1, 6, 0, 0);
    expectOut("bypass_same", 0, 1, BYP ? 16'hAA : 16'h33, 0, 0, 1, !BYP, 1, 5'd2, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 6, 0, 0);
    expectOut("bypass_next", 0, 1, 16'hAA, 0, 0, 1, 0, 1, 5'd1, 0, 0);

    // Asynchronous reset mid-run discards data, reservations and the sticky error
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 4, 1, 3);
    expectOut("pre_reset", 0, 1, 16'h00, 1, 16'hBB, 1, 1, 1, 5'd1, 1, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    expectOut("async_reset", 0, 1, 16'h00, 1, 16'h00, 1, 0, 1, 5'd0, 1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 4, 1, 3);
    expectOut("post_reset", 0, 1, 16'h00, 1, 16'h00, 1, 0, 1, 5'd0, 1, 0);

    // 16x16 build: reserve every register, no counter wrap
    for (int i = 0; i < 16; i++) begin
      drive16(0, 0, 16'h0000, 1, 4'(i), 0, 0, 0, 0);
    end
    drive16(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    expectOut("full_count", 1, 0, 0, 0, 0, 1, 0, 1, 5'd16, 1, 0);
    drive16(0, 0, 16'h0000, 0, 0, 1, 15, 0, 0);
    expectOut("full_hazard", 1, 0, 0, 0, 0, 1, 1, 1, 5'd16, 0, 0);
    drive16(0, 0, 16'h0000, 1, 0, 0, 0, 0, 0);
    drive16(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    expectOut("full_no_wrap", 1, 0, 0, 0, 0, 1, 0, 1, 5'd16, 1, 1);
    drive16(1, 9, 16'hBEEF, 0, 0, 0, 0, 0, 0);
    drive16(0, 0, 16'h0000, 0, 0, 0, 9, 0, 9);
    expectOut("wide_data", 1, 1, 16'hBEEF, 1, 16'hBEEF, 1, 0, 1, 5'd15, 1, 1);

    repeat (2) @(negedge clk);
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatch++;
      $display("[TB] FAIL queue_drain: got %0d pending, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
